// File: rtl/router_pkg.sv
// router_pkg: header field positions shared by the router blocks and the
// state type of the link arbiter.
package router_pkg;

  localparam int HDR_DEST_MSB = 63;
  localparam int HDR_DEST_LSB = 56;
  localparam int HDR_SRC_MSB  = 55;
  localparam int HDR_SRC_LSB  = 48;
  localparam int HDR_LEN_MSB  = 47;
  localparam int HDR_LEN_LSB  = 40;
  localparam int HDR_LEN_W    = 8;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  // One-hot grant for a link select bit (0 = link 1, 1 = link 2).
  function automatic logic [1:0] port_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice. The output is the head register,
// so an accepted beat shows up one cycle later. The input ready is registered
// and is high only when at most one entry is in use, which keeps a free slot
// for the beat that may arrive while the registered ready is catching up.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q;
  logic             push, pop;

  assign push = s_valid_i & ready_q;
  assign pop  = (count_q != 2'd0) & m_ready_i;

  // Next occupancy; the head always holds the oldest beat.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data_i;
        end else if (push) begin
          tail_d  = s_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  // Storage, occupancy and registered ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (count_d == 2'd0) | ((count_d == 2'd1) & m_ready_i);
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = head_q;
  assign m_valid_o = (count_q != 2'd0);

endmodule

// File: rtl/router_arbiter.sv
// router_arbiter: packet-locked round-robin merge of AXI-S links 1 and 2 into
// one stream through a 2-entry skid stage. Optional header length checker is
// compiled in with ROUTER_ARB_LEN_CHECK_EN; without it err_len is tied low.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef KEEP_WIDTH
`define KEEP_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef DEST_WIDTH
`define DEST_WIDTH 4
`endif

module router_arbiter
  import router_pkg::*;
#(
  parameter int FIRST_PRIO = 1,
  parameter int LEN_MSB    = HDR_LEN_MSB
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [`DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [`KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                   s_axis_tvalid_1,
  input  logic                   s_axis_tlast_1,
  input  logic [`ID_WIDTH-1:0]   s_axis_tid_1,
  input  logic [`DEST_WIDTH-1:0] s_axis_tdest_1,
  output logic                   s_axis_tready_1,
  input  logic [`DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [`KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                   s_axis_tvalid_2,
  input  logic                   s_axis_tlast_2,
  input  logic [`ID_WIDTH-1:0]   s_axis_tid_2,
  input  logic [`DEST_WIDTH-1:0] s_axis_tdest_2,
  output logic                   s_axis_tready_2,
  output logic [`DATA_WIDTH-1:0] m_axis_tdata,
  output logic [`KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [`ID_WIDTH-1:0]   m_axis_tid,
  output logic [`DEST_WIDTH-1:0] m_axis_tdest,
  input  logic                   m_axis_tready,
  output logic [1:0]             grant,
  output logic                   err_len
);

  localparam int BEAT_W = `DATA_WIDTH + `KEEP_WIDTH + 1 + `ID_WIDTH + `DEST_WIDTH;

  if (FIRST_PRIO != 1 && FIRST_PRIO != 2) begin : g_bad_first_prio
    $error("router_arbiter: FIRST_PRIO must be 1 or 2");
  end
  if (LEN_MSB < HDR_LEN_W - 1 || LEN_MSB >= `DATA_WIDTH) begin : g_bad_len_msb
    $error("router_arbiter: LEN_MSB outside tdata");
  end

  arb_state_t        state_q;
  logic [1:0]        grant_q;
  logic              ptr_q;      // 0: link 1 favoured, 1: link 2 favoured
  logic              skid_ready;
  logic              sel_valid;
  logic              sel_last;
  logic              accept;
  logic [BEAT_W-1:0] beat_1, beat_2, sel_beat, out_beat;
  logic              out_valid;

  assign beat_1 = {s_axis_tdata_1, s_axis_tkeep_1, s_axis_tlast_1, s_axis_tid_1, s_axis_tdest_1};
  assign beat_2 = {s_axis_tdata_2, s_axis_tkeep_2, s_axis_tlast_2, s_axis_tid_2, s_axis_tdest_2};

  assign sel_beat  = grant_q[1] ? beat_2 : beat_1;
  assign sel_last  = grant_q[1] ? s_axis_tlast_2 : s_axis_tlast_1;
  assign sel_valid = (grant_q[0] & s_axis_tvalid_1) | (grant_q[1] & s_axis_tvalid_2);
  assign accept    = sel_valid & skid_ready;

  assign s_axis_tready_1 = grant_q[0] & skid_ready;
  assign s_axis_tready_2 = grant_q[1] & skid_ready;
  assign grant           = grant_q;

  // Arbitration: pick an owner in IDLE, hold it until its tlast is accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= (FIRST_PRIO == 2);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (s_axis_tvalid_1 | s_axis_tvalid_2) begin
            if (ptr_q ? s_axis_tvalid_2 : s_axis_tvalid_1) grant_q <= port_onehot(ptr_q);
            else                                           grant_q <= port_onehot(~ptr_q);
            state_q <= ARB_PASS;
          end
        end
        default: begin
          if (accept & sel_last) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
            ptr_q   <= ~grant_q[1];
          end
        end
      endcase
    end
  end

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk_i    (aclk),
    .rst_i    (areset),
    .s_data_i (sel_beat),
    .s_valid_i(sel_valid),
    .s_ready_o(skid_ready),
    .m_data_o (out_beat),
    .m_valid_o(out_valid),
    .m_ready_i(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest} = out_beat;
  assign m_axis_tvalid = out_valid;

`ifdef ROUTER_ARB_LEN_CHECK_EN
  logic [8:0]           beat_cnt_q;
  logic [HDR_LEN_W-1:0] len_q;
  logic                 err_q;
  logic [`DATA_WIDTH-1:0] sel_data;
  logic [HDR_LEN_W-1:0] cur_len;
  logic [9:0]           beat_num;
  logic [9:0]           beat_want;

  assign sel_data  = grant_q[1] ? s_axis_tdata_2 : s_axis_tdata_1;
  assign cur_len   = (beat_cnt_q == 9'd0) ? sel_data[LEN_MSB -: HDR_LEN_W] : len_q;
  assign beat_num  = {1'b0, beat_cnt_q} + 10'd1;
  assign beat_want = {2'b00, cur_len} + 10'd1;

  // Count beats of the owned packet; flag tlast not landing exactly on beat len+1.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt_q <= 9'd0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      len_q <= cur_len;
      if ((beat_num == beat_want) != sel_last) err_q <= 1'b1;
      if (sel_last)                 beat_cnt_q <= 9'd0;
      else if (beat_cnt_q != 9'h1FF) beat_cnt_q <= beat_cnt_q + 9'd1;
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef KEEP_WIDTH
`define KEEP_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef DEST_WIDTH
`define DEST_WIDTH 4
`endif

module tb_router_arbiter;

  localparam int DW = `DATA_WIDTH;
  localparam int KW = `KEEP_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int TW = `DEST_WIDTH;
  localparam int BW = DW + KW + 1 + IW + TW;
  localparam int FIRST_PRIO = 1;
`ifdef ROUTER_ARB_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [BW-1:0] beat;
    logic [7:0]    gap;
  } txb_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata_1, s_axis_tdata_2, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep_1, s_axis_tkeep_2, m_axis_tkeep;
  logic          s_axis_tvalid_1, s_axis_tvalid_2, m_axis_tvalid;
  logic          s_axis_tlast_1, s_axis_tlast_2, m_axis_tlast;
  logic [IW-1:0] s_axis_tid_1, s_axis_tid_2, m_axis_tid;
  logic [TW-1:0] s_axis_tdest_1, s_axis_tdest_2, m_axis_tdest;
  logic          s_axis_tready_1, s_axis_tready_2, m_axis_tready;
  logic [1:0]    grant;
  logic          err_len;

  always #5 aclk = ~aclk;

  router_arbiter #(.FIRST_PRIO(FIRST_PRIO), .LEN_MSB(47)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tkeep_1(s_axis_tkeep_1),
    .s_axis_tvalid_1(s_axis_tvalid_1), .s_axis_tlast_1(s_axis_tlast_1),
    .s_axis_tid_1(s_axis_tid_1), .s_axis_tdest_1(s_axis_tdest_1),
    .s_axis_tready_1(s_axis_tready_1),
    .s_axis_tdata_2(s_axis_tdata_2), .s_axis_tkeep_2(s_axis_tkeep_2),
    .s_axis_tvalid_2(s_axis_tvalid_2), .s_axis_tlast_2(s_axis_tlast_2),
    .s_axis_tid_2(s_axis_tid_2), .s_axis_tdest_2(s_axis_tdest_2),
    .s_axis_tready_2(s_axis_tready_2),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tready(m_axis_tready),
    .grant(grant), .err_len(err_len)
  );

  int n_checks = 0;
  int n_errors = 0;

  txb_t          q1[$], q2[$];
  logic [BW-1:0] expq[$];
  int            hdr_link[$], hdr_cyc[$], tl_cyc[$];
  int            prob, rdy_mode, cyc, ptr, bcnt, blen, gapc1, gapc2, acc1_cnt;
  logic          act1, act2, exp_err, prev_stall, out_in_pkt;
  logic [1:0]    exp_grant;
  logic [BW-1:0] prev_beat;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic beat_last(input logic [BW-1:0] b);
    return b[IW+TW];
  endfunction

  task automatic make_pkt(input int link, input int nb, input int lenf,
                          input int rand_gaps, input int gap_at, input int gap_len);
    for (int i = 0; i < nb; i++) begin
      txb_t          t;
      logic [DW-1:0] d;
      logic [IW-1:0] id;
      d = {$urandom(), $urandom()};
      if (i == 0) d[47:40] = lenf[7:0];
      id = IW'($urandom());
      id[0] = (link == 2);
      t.beat = {d, KW'($urandom()), (i == nb - 1), id, TW'($urandom())};
      if (rand_gaps != 0) t.gap = ($urandom_range(99) < 25) ? 8'($urandom_range(3, 1)) : 8'd0;
      else                t.gap = (i == gap_at) ? 8'(gap_len) : 8'd0;
      if (link == 1) q1.push_back(t);
      else           q2.push_back(t);
    end
  endtask

  task automatic drive_inputs();
    if (!act1 && q1.size() > 0) begin
      if (gapc1 < int'(q1[0].gap)) gapc1++;
      else if ($urandom_range(99) < prob) begin act1 = 1'b1; gapc1 = 0; end
    end
    if (!act2 && q2.size() > 0) begin
      if (gapc2 < int'(q2[0].gap)) gapc2++;
      else if ($urandom_range(99) < prob) begin act2 = 1'b1; gapc2 = 0; end
    end
    {s_axis_tdata_1, s_axis_tkeep_1, s_axis_tlast_1, s_axis_tid_1, s_axis_tdest_1} =
      act1 ? q1[0].beat : '0;
    {s_axis_tdata_2, s_axis_tkeep_2, s_axis_tlast_2, s_axis_tid_2, s_axis_tdest_2} =
      act2 ? q2[0].beat : '0;
    s_axis_tvalid_1 = act1;
    s_axis_tvalid_2 = act2;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 3 == 0);
      default: m_axis_tready = ($urandom_range(99) < 60);
    endcase
  endtask

  // Reference for an input beat entering the merged stream.
  task automatic accept_beat(input logic [BW-1:0] b);
    int idx;
    expq.push_back(b);
    if (bcnt == 0) blen = int'(b[BW-DW+47 -: 8]);
    idx = bcnt + 1;
`ifdef ROUTER_ARB_LEN_CHECK_EN
    if ((idx == blen + 1) != beat_last(b)) exp_err = 1'b1;
`endif
    bcnt = beat_last(b) ? 0 : idx;
  endtask

  task automatic tick();
    logic          v1, v2, a1, a2, ao;
    logic [BW-1:0] ob;
    drive_inputs();
    @(negedge aclk);
    ob = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest};
    check_eq("grant", grant, exp_grant);
    if (!exp_grant[0]) check_eq("tready_1_not_owner", s_axis_tready_1, 0);
    if (!exp_grant[1]) check_eq("tready_2_not_owner", s_axis_tready_2, 0);
    check_eq("m_tvalid", m_axis_tvalid, expq.size() != 0);
    if (m_axis_tvalid && expq.size() != 0) check_eq("m_beat", ob, expq[0]);
    if (prev_stall) check_eq("stall_hold", {m_axis_tvalid, ob}, {1'b1, prev_beat});
    check_eq("err_len", err_len, exp_err);
    v1 = s_axis_tvalid_1;
    v2 = s_axis_tvalid_2;
    a1 = v1 & s_axis_tready_1;
    a2 = v2 & s_axis_tready_2;
    ao = m_axis_tvalid & m_axis_tready;
    prev_stall = m_axis_tvalid & ~m_axis_tready;
    prev_beat  = ob;
    @(posedge aclk);
    if (ao && expq.size() != 0) begin
      void'(expq.pop_front());
      if (!out_in_pkt) begin
        hdr_link.push_back(int'(ob[TW]));
        hdr_cyc.push_back(cyc);
      end
      if (beat_last(ob)) tl_cyc.push_back(cyc);
      out_in_pkt = ~beat_last(ob);
    end
    if (exp_grant == 2'b00) begin
      if (v1 | v2) begin
        if (ptr == 1) exp_grant = v1 ? 2'b01 : 2'b10;
        else          exp_grant = v2 ? 2'b10 : 2'b01;
      end
    end else if ((a1 && exp_grant[0] && beat_last(q1[0].beat)) ||
                 (a2 && exp_grant[1] && beat_last(q2[0].beat))) begin
      ptr       = exp_grant[0] ? 2 : 1;
      exp_grant = 2'b00;
    end
    if (a1 && q1.size() > 0) begin
      accept_beat(q1[0].beat);
      void'(q1.pop_front());
      act1 = 1'b0;
      acc1_cnt++;
    end
    if (a2 && q2.size() > 0) begin
      accept_beat(q2[0].beat);
      void'(q2.pop_front());
      act2 = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    q1.delete(); q2.delete(); expq.delete();
    hdr_link.delete(); hdr_cyc.delete(); tl_cyc.delete();
    act1 = 1'b0; act2 = 1'b0; gapc1 = 0; gapc2 = 0; acc1_cnt = 0;
    exp_grant = 2'b00; ptr = FIRST_PRIO; bcnt = 0; blen = 0; exp_err = 1'b0;
    prev_stall = 1'b0; prev_beat = '0; out_in_pkt = 1'b0;
    areset = 1'b1;
    drive_inputs();
    @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_tready", {s_axis_tready_1, s_axis_tready_2}, 0);
    check_eq("rst_m_data", {m_axis_tdata, m_axis_tlast, m_axis_tid}, 0);
    check_eq("rst_err_len", err_len, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((q1.size() + q2.size() + expq.size() != 0 || act1 || act2) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain", q1.size() + q2.size() + expq.size(), 0);
  endtask

  initial begin
    cyc = 0; prob = 100; rdy_mode = 0;
    m_axis_tready = 1'b1;
    do_reset();

    // Single link 1 packet, 4 beats, downstream always ready.
    make_pkt(1, 4, 3, 0, -1, 0);
    run_drain(60);
    check_eq("t1_pkts", hdr_link.size(), 1);
    if (hdr_cyc.size() == 1 && tl_cyc.size() == 1)
      check_eq("t1_span", tl_cyc[0] - hdr_cyc[0], 3);

    // Both links busy with 3-beat packets: strict alternation, 1-cycle bubble.
    do_reset();
    make_pkt(1, 3, 2, 0, -1, 0); make_pkt(1, 3, 2, 0, -1, 0);
    make_pkt(2, 3, 2, 0, -1, 0); make_pkt(2, 3, 2, 0, -1, 0);
    run_drain(80);
    begin
      int order;
      order = 0;
      foreach (hdr_link[i]) order = (order << 1) | hdr_link[i];
      check_eq("t2_order", {hdr_link.size(), order}, {32'd4, 32'b0101});
      for (int i = 0; i < tl_cyc.size() && i < hdr_cyc.size(); i++) begin
        check_eq("t2_contiguous", tl_cyc[i] - hdr_cyc[i], 2);
        if (i > 0) check_eq("t2_bubble", hdr_cyc[i] - tl_cyc[i-1], 2);
      end
    end

    // Downstream ready pattern 1,0,0: beats held stable, none lost.
    do_reset();
    rdy_mode = 1;
    make_pkt(1, 6, 5, 0, -1, 0);
    run_drain(100);
    rdy_mode = 0;

    // Link 2 owns and stalls 5 cycles mid-packet while link 1 waits.
    do_reset();
    make_pkt(2, 5, 4, 0, 2, 5);
    make_pkt(1, 3, 2, 0, 0, 1);
    run_drain(100);
    check_eq("t4_order", {hdr_link.size(), (hdr_link.size() == 2) ? hdr_link[0] * 2 + hdr_link[1] : -1},
             {32'd2, 32'd2});

    // Reset on beat 2 of a link 1 packet, then both links request together.
    do_reset();
    make_pkt(1, 5, 4, 0, -1, 0);
    for (int n = 0; n < 40 && acc1_cnt < 2; n++) tick();
    check_eq("t5_reached_beat2", acc1_cnt, 2);
    do_reset();
    make_pkt(2, 2, 1, 0, -1, 0);
    make_pkt(1, 2, 1, 0, -1, 0);
    run_drain(60);
    check_eq("t5_first_link1", (hdr_link.size() > 0) ? hdr_link[0] : -1, 0);

    // Header length checks: good, short, then good again (sticky).
    do_reset();
    make_pkt(1, 3, 2, 0, -1, 0);
    run_drain(40);
    check_eq("len_ok", err_len, 0);
    make_pkt(1, 2, 2, 0, -1, 0);
    run_drain(40);
    check_eq("len_short", err_len, LEN_CHK);
    make_pkt(1, 3, 2, 0, -1, 0);
    run_drain(40);
    check_eq("len_sticky", err_len, LEN_CHK);

    // Randomized traffic, gaps and backpressure.
    do_reset();
    prob = 70; rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      for (int l = 1; l <= 2; l++) begin
        int nb;
        nb = int'($urandom_range(6, 1));
        make_pkt(l, nb, ($urandom_range(99) < 80) ? nb - 1 : int'($urandom_range(7)), 1, -1, 0);
      end
    end
    run_drain(8000);
    check_eq("rand_pkts", hdr_link.size(), 60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
